instruction_memory_loadable: RTL
================================

Name: instruction_memory_loadable

Overview:
Parametrised, synchronous-read instruction memory for the single-cycle SimpleRisc core, the next generation of the flat-vector combinational ROM. Programs load serially through a valid/ready port driven by the testbench or boot logic. A small FSM gates fetches until loading completes. Fetch has registered 1-cycle latency, and misaligned or out-of-range PCs are flagged and substituted with a NOP.

Parameters:
DATA_WIDTH, 32, instruction word width in bits
ADDR_WIDTH, 8, word-address width; DEPTH = 2**ADDR_WIDTH words (default 256)
PC_WIDTH, 32, width of byte-addressed PC
NOP_WORD, 32'h68000000, SimpleRisc nop encoding returned on any faulted fetch

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
load_start  input  1  pulse: begin (re)loading program from word 0
load_valid  input  1  load_data valid this cycle
load_data  input  DATA_WIDTH  instruction word to write
load_last  input  1  qualifies load_valid: this is the final word
load_ready  output  1  block accepts load words (high only in LOADING)
load_done  output  1  one-cycle pulse when loading finishes
fetch_req  input  1  fetch request for pc this cycle
pc  input  PC_WIDTH  byte address of instruction
instruction  output  DATA_WIDTH  fetched word (registered)
instr_valid  output  1  one-cycle pulse: instruction updated by a fetch
misaligned  output  1  registered with instruction: pc[1:0] != 0
out_of_range  output  1  registered with instruction: pc beyond DEPTH words

Behaviour:
- States: IDLE, LOADING, READY. Reset forces IDLE. All outputs go to 0, except instruction, which goes to NOP_WORD. The load counter is cleared. Memory contents are not cleared by reset.
- IDLE: load_start -> LOADING. fetch_req is ignored.
- LOADING: load_ready=1. Each cycle with load_valid=1 writes mem[cnt] <= load_data, then cnt <= cnt+1.
- LOADING exit: if load_last=1 on an accepted word, or cnt==DEPTH-1 on an accepted word, transition to READY next edge and pulse load_done for exactly that one cycle. cnt never wraps.
- LOADING: load_start restarts loading from cnt=0 and ignores any same-cycle load_valid.
- LOADING: fetch_req is ignored and instr_valid stays 0.
- READY: load_start -> LOADING, cnt=0. A same-cycle fetch_req is still serviced. load_valid is ignored.
- Fetch (READY only): fetch_req=1 at edge N latches a result; instruction, instr_valid=1 and the flags are visible after edge N+1 (1-cycle latency). Back-to-back fetches give one result per cycle.
- Word index = pc[ADDR_WIDTH+1:2].
- misaligned = pc[1:0]!=0.
- out_of_range = |pc[PC_WIDTH-1:ADDR_WIDTH+2].
- If either flag is set, instruction <= NOP_WORD. Both flags may be set together.
- With no fetch: instr_valid=0; instruction and flags hold their last values.
- Read-during-load is impossible by FSM construction. Memory has one write port and one read port, so it maps to block RAM.
- Reset asserted mid-load: immediate return to IDLE. Words already written persist, and a new load_start is required.

Test Plan:
- Reset, then load_start, then 4 words 0x10000001..0x10000004 with load_last on the 4th -> load_ready high for those cycles; load_done pulses 1 cycle; state READY.
- In READY, fetch pc=0x0,0x4,0x8,0xC back-to-back -> instruction = 0x10000001..0x10000004 one cycle after each request; instr_valid high 4 cycles; flags 0.
- Fetch pc=0x6 -> instruction=0x68000000, misaligned=1. Fetch pc=0x400 (DEPTH=256) -> NOP_WORD, out_of_range=1. Fetch pc=0x402 -> both flags set.
- Load 256 words without load_last -> auto READY after word 255, load_done pulse. Fetch pc=0x3FC returns word 255. Additional load_valid is ignored.
- Assert reset after 2 of 4 load words -> outputs zeroed, instruction=NOP_WORD, IDLE. fetch_req ignored (instr_valid stays 0) until a new load completes.
- Fetch in IDLE and during LOADING -> instr_valid stays 0. load_start while in READY with simultaneous fetch_req -> fetch result delivered, then load_ready=1.

Source files
------------

// File: rtl/instruction_memory_loadable.sv
// Loadable instruction memory for the SimpleRisc core.
// A program is streamed in word by word through a valid/ready port, starting
// at word 0. Fetches are only honoured once a load has completed. Fetch
// results appear one cycle after the request. A misaligned or out-of-range PC
// is flagged, and a NOP is returned in place of the memory word.

module instruction_memory_loadable #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int PC_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h68000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  input  logic                  fetch_req,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  output logic                  misaligned,
  output logic                  out_of_range
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    LOADING,
    READY
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // The read data register and the NOP-select flag are kept apart. This lets
  // the array and its output register map onto a plain block RAM. The NOP
  // substitution is then a mux after that RAM.
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    use_nop;

  logic [ADDR_WIDTH-1:0]   fetch_index;
  logic                    pc_misaligned;
  logic                    pc_out_of_range;
  logic                    write_en;
  logic                    load_final;
  logic                    fetch_en;

  assign fetch_index     = pc[ADDR_WIDTH+1:2];
  assign pc_misaligned   = (pc[1:0] != 2'b00);
  assign pc_out_of_range = |pc[PC_WIDTH-1:ADDR_WIDTH+2];

  // A load_start in LOADING restarts the load, so any word offered in the
  // same cycle is dropped rather than written.
  assign write_en   = (state == LOADING) && load_valid && !load_start;
  assign load_final = write_en && (load_last || (cnt == LAST_INDEX));
  assign fetch_en   = (state == READY) && fetch_req;

  assign load_ready  = (state == LOADING);
  assign instruction = use_nop ? NOP_WORD : read_data;

  // This process sequences the load. It tracks the write pointer, moves
  // between the three phases, and raises load_done as a one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state <= LOADING;
            cnt   <= '0;
          end
        end
        LOADING: begin
          if (load_start) begin
            cnt <= '0;
          end else if (load_final) begin
            state     <= READY;
            load_done <= 1'b1;
          end else if (write_en) begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          if (load_start) begin
            state <= LOADING;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // This is the single write port and the single registered read port.
  // Contents survive reset on purpose, so a partial load is still visible
  // after a later load that does not overwrite it.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[cnt] <= load_data;
    end
    if (fetch_en && !pc_misaligned && !pc_out_of_range) begin
      read_data <= mem[fetch_index];
    end
  end

  // This process registers the fetch status. The flags and the NOP select
  // only change on a serviced fetch; otherwise the last result is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid  <= 1'b0;
      misaligned   <= 1'b0;
      out_of_range <= 1'b0;
      use_nop      <= 1'b1;
    end else begin
      instr_valid <= fetch_en;
      if (fetch_en) begin
        misaligned   <= pc_misaligned;
        out_of_range <= pc_out_of_range;
        use_nop      <= pc_misaligned || pc_out_of_range;
      end
    end
  end

endmodule
